// File: rtl/sum_accumulator.sv
// sum_accumulator: sums a run of 4-bit beats into a 6-bit modulo-64 total.
// A run starts from IDLE on start, accepts beats over a valid/ready
// handshake until the latched length is reached, then pulses done once.
module sum_accumulator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] length,
  input  logic [3:0] sum_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] acc,
  output logic [4:0] count,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] target;
  logic [6:0] sum_wide;
  logic [4:0] count_inc;
  logic       accept;
  logic       run_start;

  assign run_start = (state == IDLE) && start;
  assign accept    = (state == ACCUM) && in_valid;
  assign sum_wide  = {1'b0, acc} + {3'b000, sum_in};
  assign count_inc = count + 5'd1;

  // Output decode straight from the registered state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic: the last accepted beat moves straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (accept && (count_inc == target)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: clear on run start, accumulate on accepted beats, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target   <= '0;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (run_start) begin
      target   <= (length == 4'd0) ? 5'd16 : {1'b0, length};
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      acc   <= sum_wide[5:0];
      count <= count_inc;
      if (sum_wide[6]) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator: directed runs with hand-computed results.
// Expected run results are queued at run start; a monitor pops and compares
// them whenever the DUT pulses done.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] length = '0;
  logic [3:0] sum_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] acc;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic       overflow;

  typedef struct {
    int acc;
    int count;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failed = 0;
  int   done_seen = 0;

  sum_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .length   (length),
    .sum_in   (sum_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc      (acc),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    length = len[3:0];
    tick();
    start  = 1'b0;
  endtask

  task automatic beat(input int v);
    in_valid = 1'b1;
    sum_in   = v[3:0];
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_run(input int a, input int c, input int o);
    exp_t e;
    e.acc = a;
    e.count = c;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Monitor: score every done pulse against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      check("done_busy", int'(busy), 1);
      check("done_in_ready", int'(in_ready), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("run_acc", int'(acc), e.acc);
        check("run_count", int'(count), e.count);
        check("run_overflow", int'(overflow), e.ovf);
      end
    end
  end

  initial begin
    int d0;

    // Reset: two cycles low, everything zero and idle.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_acc", int'(acc), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    tick();

    // Basic run: 3 + 5 + 15 = 23.
    d0 = done_seen;
    expect_run(23, 3, 0);
    do_start(3);
    check("accum_in_ready", int'(in_ready), 1);
    check("accum_busy", int'(busy), 1);
    beat(3);
    beat(5);
    beat(15);
    check("basic_done_now", int'(done), 1);
    tick();
    check("basic_done_once", done_seen - d0, 1);
    check("basic_busy_clear", int'(busy), 0);
    check("basic_done_clear", int'(done), 0);
    tick();
    tick();
    check("basic_hold_acc", int'(acc), 23);
    check("basic_no_extra_done", done_seen - d0, 1);

    // Overflow: 5 x 15 = 75 -> 11 with carry out.
    expect_run(11, 5, 1);
    do_start(5);
    for (int i = 0; i < 5; i++) beat(15);
    tick();
    check("ovf_sticky_idle", int'(overflow), 1);
    check("ovf_hold_acc", int'(acc), 11);
    expect_run(2, 1, 0);
    do_start(1);
    check("ovf_cleared_on_start", int'(overflow), 0);
    check("acc_cleared_on_start", int'(acc), 0);
    beat(2);
    tick();

    // Stalls with an ignored start in the gap: 7 + 9 = 16.
    d0 = done_seen;
    expect_run(16, 2, 0);
    do_start(2);
    beat(7);
    tick();
    start = 1'b1;
    length = 4'd1;
    tick();
    start = 1'b0;
    tick();
    check("stall_busy", int'(busy), 1);
    check("stall_count", int'(count), 1);
    check("stall_acc", int'(acc), 7);
    beat(9);
    tick();
    check("stall_done_once", done_seen - d0, 1);

    // in_valid in IDLE must not change acc or count.
    in_valid = 1'b1;
    sum_in = 4'd5;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_valid_acc", int'(acc), 16);
    check("idle_valid_count", int'(count), 2);
    check("idle_valid_busy", int'(busy), 0);

    // Length zero means sixteen beats.
    d0 = done_seen;
    expect_run(16, 16, 0);
    do_start(0);
    for (int i = 0; i < 15; i++) beat(1);
    check("len0_count15", int'(count), 15);
    check("len0_still_busy", int'(in_ready), 1);
    check("len0_no_early_done", done_seen - d0, 0);
    beat(1);
    tick();
    check("len0_done_once", done_seen - d0, 1);

    // Reset mid-run: no done, everything cleared, then a fresh run.
    d0 = done_seen;
    do_start(4);
    beat(2);
    beat(3);
    check("mid_count_before_rst", int'(count), 2);
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    sum_in = 4'd6;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    check("midrst_acc", int'(acc), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    tick();
    tick();
    check("midrst_no_done", done_seen - d0, 0);
    expect_run(4, 1, 0);
    do_start(1);
    beat(4);
    tick();
    check("post_rst_done", done_seen - d0, 1);
    check("post_rst_acc", int'(acc), 4);

    tick();
    check("all_runs_scored", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Safety bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1);
  end

endmodule
